imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single synchronous instruction-memory read port (registered address, data valid
//  MEM_LATENCY cycles later) between the CPU fetch stage (port F) and the debug/dump reader (port D).
//  Fetch has priority; a starvation counter guarantees D progress. Each response is tagged back to
//  its requester. Sits between the fetch stage and the instruction ROM/BRAM.
// PARAMETERS
//  AW           30  word-address width
//  DW           32  instruction width
//  MEM_LATENCY   1  cycles from mem_addr to valid mem_inst (legal 1..4)
//  STARVE_LIMIT  8  consecutive cycles D may be denied while requesting before forced grant (>=1)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous, active-low reset
//  f_req       in   1   fetch request valid
//  f_addr      in   AW  fetch word address
//  f_gnt       out  1   fetch request accepted this cycle
//  f_rvalid    out  1   f_rdata valid
//  f_rdata     out  DW  fetch instruction
//  d_req       in   1   debug request valid
//  d_addr      in   AW  debug word address
//  d_gnt       out  1   debug request accepted this cycle
//  d_rvalid    out  1   d_rdata valid
//  d_rdata     out  DW  debug instruction
//  mem_addr    out  AW  address to memory (sampled by memory each clk)
//  mem_inst    in   DW  memory read data
// BEHAVIOUR
//  - Handshake: request accepted in cycle where req && gnt; requester holds req/addr until gnt.
//    gnt is combinational from req and state; never both gnt high in one cycle.
//  - Arbitration FSM, 2 states:
//    PRI_F: f_req -> F granted; else d_req -> D granted. If d_req && !d_gnt, starve_cnt++;
//      starve_cnt==STARVE_LIMIT-1 with D still denied -> next state FORCE_D. D granted -> cnt=0.
//    FORCE_D: D granted if d_req (F stalled); then cnt=0, -> PRI_F. If d_req dropped, -> PRI_F, cnt=0.
//  - mem_addr = granted requester's address; no grant -> hold previous mem_addr (data stable, idle).
//  - Tag pipe: MEM_LATENCY-deep shift register of {valid, owner}; entry at stage 0 = grant of this
//    cycle. Stage MEM_LATENCY-1 drives rvalid of owner; rdata = mem_inst registered? No: rdata is
//    mem_inst passed through combinationally, gated to zero when that port's rvalid is low.
//  - Latency: accept in cycle N -> rvalid in cycle N+MEM_LATENCY, one response per accept, in order.
//  - Back-to-back accepts allowed every cycle (full throughput); mixed F/D in flight stay tagged.
//  - starve_cnt width clog2(STARVE_LIMIT)+1, saturates, never wraps.
//  - Reset (async assert, sync to clk on deassert by top level): state PRI_F, starve_cnt 0,
//    mem_addr 0, tag pipe cleared. Outputs: f_gnt/d_gnt follow comb rules (0 when no req),
//    f_rvalid=d_rvalid=0, rdata=0. Reset mid-flight drops all outstanding responses; none emitted later.
//  - Simultaneous f_req && d_req in PRI_F below limit: F wins. Both drop: no grant, counter holds.
// STRUCTURE
//  - Shared package imem_pkg: owner tag encoding (OWN_F=0, OWN_D=1), FSM state encoding
//    (ST_PRI_F, ST_FORCE_D), default MEM_LATENCY.
//  - One sub-module: imem_tag_pipe (parameterised valid/owner delay line, async active-low clear).
// TESTING
//  1 Reset: rst=0 with tags in flight -> all rvalid 0, mem_addr 0; release, no stale rvalid.
//  2 F only, f_addr 0..5 back-to-back, LAT=1 -> f_gnt every cycle, f_rvalid next cycle with ROM words
//    in order (addr 0 -> 32'h3c0b1000, addr 1 -> 32'h356b00c8).
//  3 D only, d_addr=5 -> d_gnt same cycle, d_rvalid 1 cycle later, d_rdata=32'h11ee0015, f_rvalid 0.
//  4 F and D continuous, STARVE_LIMIT=8 -> F granted 8 cycles, D granted on 9th, F resumes;
//    pattern repeats, D response tagged correctly amid F stream.
//  5 MEM_LATENCY=3, alternating F/D grants -> each rvalid exactly 3 cycles after its accept,
//    owner matches, no cross-port data.
//  6 FORCE_D entered then d_req drops -> return to PRI_F, F granted that cycle, starve_cnt 0.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared encodings for the instruction-memory port arbiter
package imem_pkg;

   // Response owner tag carried alongside each accepted read
   localparam logic OWN_F = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Arbitration FSM states
   localparam logic [0:0] ST_PRI_F   = 1'b0;
   localparam logic [0:0] ST_FORCE_D = 1'b1;

   localparam int DEFAULT_MEM_LATENCY = 1;

   typedef struct packed {
      logic valid;
      logic owner;
   } tag_t;

endpackage

// File: rtl/imem_tag_pipe.sv
// rtl/imem_tag_pipe.sv - valid/owner delay line matching the memory read latency
module imem_tag_pipe
   import imem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_MEM_LATENCY
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_owner,
   output logic out_valid,
   output logic out_owner
);

   tag_t stage [DEPTH];

   // Shift the accept tag one stage per cycle; reset drops everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= '{valid: in_valid, owner: in_owner};
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_valid = stage[DEPTH-1].valid;
   assign out_owner = stage[DEPTH-1].owner;

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch-priority arbiter for the shared instruction-memory read port
module imem_port_arbiter
   import imem_pkg::*;
#(
   parameter int AW           = 30,
   parameter int DW           = 32,
   parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_inst
);

   localparam int CW = $clog2(STARVE_LIMIT) + 1;

   logic [0:0]    state, state_nxt;
   logic [CW-1:0] starve_cnt, cnt_nxt;
   logic [AW-1:0] addr_q;
   logic          tag_valid, tag_owner;

   // Grant decode: fetch wins in PRI_F, debug wins for the one forced cycle
   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (state == ST_FORCE_D) begin
         d_gnt = d_req;
         f_gnt = f_req && !d_req;
      end else begin
         f_gnt = f_req;
         d_gnt = d_req && !f_req;
      end
   end

   // Next state and starvation count; the counter saturates rather than wrapping
   always_comb begin
      state_nxt = state;
      cnt_nxt   = starve_cnt;
      if (state == ST_FORCE_D) begin
         state_nxt = ST_PRI_F;
         cnt_nxt   = '0;
      end else if (d_gnt) begin
         cnt_nxt = '0;
      end else if (d_req) begin
         if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
            state_nxt = ST_FORCE_D;
         end
         if (starve_cnt != '1) begin
            cnt_nxt = starve_cnt + 1'b1;
         end
      end
   end

   // Arbitration state and last-issued address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_PRI_F;
         starve_cnt <= '0;
         addr_q     <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= cnt_nxt;
         addr_q     <= mem_addr;
      end
   end

   // Idle cycles repeat the previous address so the memory input stays quiet
   assign mem_addr = f_gnt ? f_addr : (d_gnt ? d_addr : addr_q);

   imem_tag_pipe #(
      .DEPTH(MEM_LATENCY)
   ) u_tag_pipe (
      .clk      (clk),
      .rst_n    (rst),
      .in_valid (f_gnt || d_gnt),
      .in_owner (d_gnt ? OWN_D : OWN_F),
      .out_valid(tag_valid),
      .out_owner(tag_owner)
   );

   assign f_rvalid = tag_valid && (tag_owner == OWN_F);
   assign d_rvalid = tag_valid && (tag_owner == OWN_D);
   assign f_rdata  = f_rvalid ? mem_inst : '0;
   assign d_rdata  = d_rvalid ? mem_inst : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance 1: MEM_LATENCY=1, STARVE_LIMIT=8
   logic        f_req1 = 1'b0, d_req1 = 1'b0;
   logic [29:0] f_addr1 = '0, d_addr1 = '0;
   logic        f_gnt1, f_rvalid1, d_gnt1, d_rvalid1;
   logic [31:0] f_rdata1, d_rdata1, mem_inst1;
   logic [29:0] mem_addr1;

   // Instance 3: MEM_LATENCY=3, STARVE_LIMIT=8
   logic        f_req3 = 1'b0, d_req3 = 1'b0;
   logic [29:0] f_addr3 = '0, d_addr3 = '0;
   logic        f_gnt3, f_rvalid3, d_gnt3, d_rvalid3;
   logic [31:0] f_rdata3, d_rdata3, mem_inst3;
   logic [29:0] mem_addr3;

   int n_cmp = 0;
   int n_mis = 0;

   function automatic logic [31:0] rom(input logic [29:0] a);
      case (a)
         30'd0:   rom = 32'h3c0b1000;
         30'd1:   rom = 32'h356b00c8;
         30'd2:   rom = 32'h8d690000;
         30'd3:   rom = 32'h21290001;
         30'd4:   rom = 32'had690004;
         30'd5:   rom = 32'h11ee0015;
         default: rom = {2'b10, a};
      endcase
   endfunction

   // Synchronous ROMs with registered address and matching read latency
   logic [29:0] p1 = '0;
   logic [29:0] p3 [3];
   initial for (int i = 0; i < 3; i++) p3[i] = '0;
   always @(posedge clk) begin
      p1    <= mem_addr1;
      p3[0] <= mem_addr3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mem_inst1 = rom(p1);
   assign mem_inst3 = rom(p3[2]);

   imem_port_arbiter #(.AW(30), .DW(32), .MEM_LATENCY(1), .STARVE_LIMIT(8)) u_dut1 (
      .clk(clk), .rst(rst),
      .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1), .f_rdata(f_rdata1),
      .d_req(d_req1), .d_addr(d_addr1), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .mem_addr(mem_addr1), .mem_inst(mem_inst1)
   );

   imem_port_arbiter #(.AW(30), .DW(32), .MEM_LATENCY(3), .STARVE_LIMIT(8)) u_dut3 (
      .clk(clk), .rst(rst),
      .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3), .f_rdata(f_rdata3),
      .d_req(d_req3), .d_addr(d_addr3), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_addr(mem_addr3), .mem_inst(mem_inst3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic        pf, pd, exp_d;
   logic [29:0] pa;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_f_rvalid", f_rvalid1, 0);
      chk("rst_d_rvalid", d_rvalid1, 0);
      chk("rst_mem_addr", mem_addr1, 0);
      chk("rst_f_gnt", f_gnt1, 0);
      chk("rst_f_rdata", f_rdata1, 0);
      next_cycle();
      rst = 1'b1;

      // Reset with a fetch in flight drops its response
      next_cycle();
      f_req1 = 1'b1; f_addr1 = 30'd3;
      @(negedge clk);
      chk("t1_f_gnt", f_gnt1, 1);
      chk("t1_mem_addr", mem_addr1, 3);
      next_cycle();
      f_req1 = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("t1_rst_f_rvalid", f_rvalid1, 0);
      chk("t1_rst_mem_addr", mem_addr1, 0);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("t1_post_f_rvalid", f_rvalid1, 0);
      chk("t1_post_d_rvalid", d_rvalid1, 0);

      // F only, back-to-back addresses 0..5
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         f_req1 = 1'b1; f_addr1 = 30'(i);
         @(negedge clk);
         chk("t2_f_gnt", f_gnt1, 1);
         chk("t2_mem_addr", mem_addr1, 64'(i));
         if (i > 0) begin
            chk("t2_f_rvalid", f_rvalid1, 1);
            chk("t2_f_rdata", f_rdata1, rom(30'(i - 1)));
         end
         if (i == 1) chk("t2_word0", f_rdata1, 32'h3c0b1000);
         if (i == 2) chk("t2_word1", f_rdata1, 32'h356b00c8);
      end
      next_cycle();
      f_req1 = 1'b0;
      @(negedge clk);
      chk("t2_last_rvalid", f_rvalid1, 1);
      chk("t2_last_rdata", f_rdata1, 32'h11ee0015);
      chk("t2_idle_mem_addr", mem_addr1, 5);

      // D only
      next_cycle();
      d_req1 = 1'b1; d_addr1 = 30'd5;
      @(negedge clk);
      chk("t3_f_rvalid_drain", f_rvalid1, 0);
      chk("t3_d_gnt", d_gnt1, 1);
      chk("t3_f_gnt", f_gnt1, 0);
      next_cycle();
      d_req1 = 1'b0;
      @(negedge clk);
      chk("t3_d_rvalid", d_rvalid1, 1);
      chk("t3_d_rdata", d_rdata1, 32'h11ee0015);
      chk("t3_f_rvalid", f_rvalid1, 0);
      chk("t3_f_rdata", f_rdata1, 0);

      // Both continuous: D gets every 9th slot
      pf = 1'b0; pd = 1'b0; pa = '0;
      for (int c = 0; c < 20; c++) begin
         next_cycle();
         f_req1 = 1'b1; f_addr1 = 30'(16 + c);
         d_req1 = 1'b1; d_addr1 = 30'd40;
         @(negedge clk);
         exp_d = (c % 9 == 8);
         chk("t4_f_gnt", f_gnt1, !exp_d);
         chk("t4_d_gnt", d_gnt1, exp_d);
         if (c > 0) begin
            chk("t4_f_rvalid", f_rvalid1, pf);
            chk("t4_d_rvalid", d_rvalid1, pd);
            if (pd) chk("t4_d_rdata", d_rdata1, rom(30'd40));
            if (pf) chk("t4_f_rdata", f_rdata1, rom(pa));
         end
         pf = !exp_d; pd = exp_d; pa = 30'(16 + c);
      end

      // Clear the starvation count with a lone D request
      next_cycle();
      f_req1 = 1'b0;
      @(negedge clk);
      chk("t6_clr_d_gnt", d_gnt1, 1);
      chk("t6_clr_f_rvalid", f_rvalid1, 1);
      chk("t6_clr_f_rdata", f_rdata1, rom(30'd35));

      // Reach FORCE_D, then D withdraws: F must be granted in the forced slot
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         f_req1 = 1'b1; f_addr1 = 30'(64 + c);
         d_req1 = 1'b1; d_addr1 = 30'd41;
         @(negedge clk);
         chk("t6_f_gnt_pre", f_gnt1, 1);
      end
      next_cycle();
      d_req1 = 1'b0; f_addr1 = 30'd80;
      @(negedge clk);
      chk("t6_force_f_gnt", f_gnt1, 1);
      chk("t6_force_d_gnt", d_gnt1, 0);
      chk("t6_force_mem_addr", mem_addr1, 80);
      // Counter restarted from zero: eight more F wins before D
      for (int c = 0; c < 9; c++) begin
         next_cycle();
         f_req1 = 1'b1; f_addr1 = 30'(96 + c);
         d_req1 = 1'b1;
         @(negedge clk);
         chk("t6_after_f_gnt", f_gnt1, c != 8);
         chk("t6_after_d_gnt", d_gnt1, c == 8);
      end
      next_cycle();
      f_req1 = 1'b0; d_req1 = 1'b0;

      // Latency 3, alternating F/D
      for (int c = 0; c < 12; c++) begin
         next_cycle();
         f_req3 = (c < 8) && (c % 2 == 0);
         d_req3 = (c < 8) && (c % 2 == 1);
         f_addr3 = 30'(c + 8);
         d_addr3 = 30'(c + 8);
         @(negedge clk);
         if (c < 8) begin
            chk("t5_f_gnt", f_gnt3, c % 2 == 0);
            chk("t5_d_gnt", d_gnt3, c % 2 == 1);
         end
         if (c >= 3 && c < 11) begin
            if ((c - 3) % 2 == 0) begin
               chk("t5_f_rvalid", f_rvalid3, 1);
               chk("t5_d_rvalid", d_rvalid3, 0);
               chk("t5_f_rdata", f_rdata3, rom(30'(c + 5)));
               chk("t5_d_rdata_zero", d_rdata3, 0);
            end else begin
               chk("t5_d_rvalid", d_rvalid3, 1);
               chk("t5_f_rvalid", f_rvalid3, 0);
               chk("t5_d_rdata", d_rdata3, rom(30'(c + 5)));
               chk("t5_f_rdata_zero", f_rdata3, 0);
            end
         end else begin
            chk("t5_f_rvalid_idle", f_rvalid3, 0);
            chk("t5_d_rvalid_idle", d_rvalid3, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
